// File: rtl/assoc_cache_if.sv
// Request/response bundle of the set-associative cache array.
// The master drives the request side (tag/index/offset, qualifiers, write
// and refill data); the slave (the cache) returns hit, read data and the
// victim information used by the controller for write-back.
// Valid/ready note: there is no back-pressure. Every qualifier
// (read_en_cache, write_en_cache, refill) is a one-cycle request that is
// always accepted at the next rising edge; done_cache or miss is the
// response one cycle later.
interface assoc_cache_if #(
  parameter int SETS      = 64,
  parameter int WORDS     = 4,
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 32
);
  localparam int IDX_W      = $clog2(SETS);
  localparam int OFF_W      = $clog2(WORDS);
  localparam int TAG_W      = ADDR_W - IDX_W - OFF_W - 2;
  localparam int BLOCK_SIZE = WORDS * WORD_SIZE;

  logic [TAG_W-1:0]      tag;
  logic [IDX_W-1:0]      index;
  logic [OFF_W-1:0]      blk_offset;
  logic                  read_en_cache;
  logic                  write_en_cache;
  logic                  refill;
  logic [WORD_SIZE-1:0]  data_in;
  logic [BLOCK_SIZE-1:0] data_in_mem;

  logic                  hit;
  logic [WORD_SIZE-1:0]  data_out;
  logic                  done_cache;
  logic                  miss;
  logic                  dirty_bit;
  logic [BLOCK_SIZE-1:0] dirty_block_out;
  logic [TAG_W-1:0]      victim_tag;

  modport master (
    output tag, index, blk_offset, read_en_cache, write_en_cache, refill,
           data_in, data_in_mem,
    input  hit, data_out, done_cache, miss, dirty_bit, dirty_block_out,
           victim_tag
  );

  modport slave (
    input  tag, index, blk_offset, read_en_cache, write_en_cache, refill,
           data_in, data_in_mem,
    output hit, data_out, done_cache, miss, dirty_bit, dirty_block_out,
           victim_tag
  );
endinterface

// File: rtl/assoc_cache_array.sv
// Set-associative cache storage with true-LRU replacement.
// One request per cycle, priority refill > write > read. Hits answer with
// done_cache one cycle later; misses answer with miss plus the victim
// block/tag/dirty state so the controller can write back and refill.
// Optional feature macro: CACHE_PERF_CNT_EN adds saturating hit_count and
// miss_count outputs.
module assoc_cache_array #(
  parameter int WAYS      = 2,
  parameter int SETS      = 64,
  parameter int WORDS     = 4,
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  assoc_cache_if.slave bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IDX_W      = $clog2(SETS);
  localparam int OFF_W      = $clog2(WORDS);
  localparam int TAG_W      = ADDR_W - IDX_W - OFF_W - 2;
  localparam int BLOCK_SIZE = WORDS * WORD_SIZE;
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Storage: data and tags carry no reset, only valid/dirty are cleared.
  logic [BLOCK_SIZE-1:0] data_q  [SETS][WAYS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];

  logic                  done_q, miss_q, dirty_bit_q;
  logic [WORD_SIZE-1:0]  data_out_q;
  logic [BLOCK_SIZE-1:0] dirty_block_q;
  logic [TAG_W-1:0]      victim_tag_q;

  logic [WAYS-1:0]       match;
  logic                  hit_w;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      lru_way;
  logic [WAY_W-1:0]      victim_way;
  logic                  touch_en;
  logic [WAY_W-1:0]      touch_way;
  logic                  do_refill, do_write, do_read;
  logic [BLOCK_SIZE-1:0] hit_block;

  assign do_refill = bus.refill;
  assign do_write  = bus.write_en_cache && !bus.refill;
  assign do_read   = bus.read_en_cache && !bus.write_en_cache && !bus.refill;

  // Tag compare across the ways of the selected set.
  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[bus.index][w] && (tag_q[bus.index][w] == bus.tag);
      if (match[w]) hit_way = WAY_W'(w);
    end
    hit_w     = |match;
    hit_block = data_q[bus.index][hit_way];
  end

  // Victim: lowest-index invalid way, otherwise the LRU way.
  always_comb begin
    logic found;
    found      = 1'b0;
    victim_way = lru_way;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_q[bus.index][w] && !found) begin
        victim_way = WAY_W'(w);
        found      = 1'b1;
      end
    end
  end

  // Which way (if any) becomes MRU this cycle.
  always_comb begin
    touch_en  = !rst && (do_refill || ((do_write || do_read) && hit_w));
    touch_way = do_refill ? victim_way : hit_way;
  end

  generate
    if (WAYS > 1) begin : g_lru
      logic [WAY_W-1:0] age_q [SETS][WAYS];

      // The way whose age is WAYS-1 is least recently used.
      always_comb begin
        lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[bus.index][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
        end
      end

      // Age update: touched way -> 0, younger ways age by one, older hold.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              age_q[s][w] <= WAY_W'(w);
        end else if (touch_en) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way)
              age_q[bus.index][w] <= '0;
            else if (age_q[bus.index][w] < age_q[bus.index][touch_way])
              age_q[bus.index][w] <= age_q[bus.index][w] + 1'b1;
          end
        end
      end
    end else begin : g_dm
      assign lru_way = '0;
    end
  endgenerate

  // Data and tag array writes (refill installs a block, write hit a word).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_refill) begin
        data_q[bus.index][victim_way] <= bus.data_in_mem;
        tag_q[bus.index][victim_way]  <= bus.tag;
      end else if (do_write && hit_w) begin
        data_q[bus.index][hit_way][bus.blk_offset*WORD_SIZE +: WORD_SIZE] <= bus.data_in;
      end
    end
  end

  // Valid/dirty state and registered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
      done_q        <= 1'b0;
      miss_q        <= 1'b0;
      dirty_bit_q   <= 1'b0;
      data_out_q    <= '0;
      dirty_block_q <= '0;
      victim_tag_q  <= '0;
    end else begin
      done_q <= 1'b0;
      miss_q <= 1'b0;
      if (do_refill) begin
        valid_q[bus.index][victim_way] <= 1'b1;
        dirty_q[bus.index][victim_way] <= 1'b0;
        done_q                         <= 1'b1;
      end else if ((do_write || do_read) && hit_w) begin
        if (do_write) dirty_q[bus.index][hit_way] <= 1'b1;
        else data_out_q <= hit_block[bus.blk_offset*WORD_SIZE +: WORD_SIZE];
        done_q <= 1'b1;
      end else if (do_write || do_read) begin
        miss_q        <= 1'b1;
        dirty_bit_q   <= valid_q[bus.index][victim_way] && dirty_q[bus.index][victim_way];
        dirty_block_q <= data_q[bus.index][victim_way];
        victim_tag_q  <= tag_q[bus.index][victim_way];
      end
    end
  end

`ifdef CACHE_PERF_CNT_EN
  // Saturating counters of completed hits and misses.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (do_write || do_read) begin
      if (hit_w && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 1'b1;
      if (!hit_w && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 1'b1;
    end
  end
`endif

  assign bus.hit             = hit_w;
  assign bus.data_out        = data_out_q;
  assign bus.done_cache      = done_q;
  assign bus.miss            = miss_q;
  assign bus.dirty_bit       = dirty_bit_q;
  assign bus.dirty_block_out = dirty_block_q;
  assign bus.victim_tag      = victim_tag_q;
endmodule

// File: doc/assoc_cache_array.md
ASSOC_CACHE_ARRAY -- requirements
Module: assoc_cache_array

Interface
REQ-001 SHALL have parameter WAYS, default 2, number of ways per set; power of 2, 1..8.
REQ-002 SHALL have parameter SETS, default 64, number of sets; power of 2.
REQ-003 SHALL have parameter WORDS, default 4, words per block; power of 2.
REQ-004 SHALL have parameter WORD_SIZE, default 32, bits per word; BLOCK_SIZE = WORDS*WORD_SIZE.
REQ-005 SHALL have parameter ADDR_W, default 32; TAG_W = ADDR_W - log2(SETS) - log2(WORDS) - 2.
REQ-006 clk  in  1  sole clock; all state changes on rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 tag  in  TAG_W  request tag.
REQ-009 index  in  log2(SETS)  set select.
REQ-010 blk_offset  in  log2(WORDS)  word select.
REQ-011 read_en_cache  in  1  CPU read request, one-cycle qualifier.
REQ-012 write_en_cache  in  1  CPU write request, one-cycle qualifier.
REQ-013 refill  in  1  install data_in_mem into victim way of index.
REQ-014 data_in  in  WORD_SIZE  CPU write data.
REQ-015 data_in_mem  in  BLOCK_SIZE  block from memory.
REQ-016 hit  out  1  combinational: some valid way of index matches tag.
REQ-017 data_out  out  WORD_SIZE  registered read data.
REQ-018 done_cache  out  1  one-cycle pulse, access or refill completed.
REQ-019 miss  out  1  registered one-cycle pulse, request missed.
REQ-020 dirty_bit  out  1  registered: victim captured on miss is valid and dirty.
REQ-021 dirty_block_out  out  BLOCK_SIZE  registered victim block.
REQ-022 victim_tag  out  TAG_W  registered victim tag (write-back address).

Function
REQ-023 Priority per cycle SHALL be refill > write > read; lower-priority requests in same cycle are dropped without response.
REQ-024 Read hit: cycle N+1 data_out = hit-way word[blk_offset], done_cache=1; that way becomes MRU.
REQ-025 Write hit: at edge N, hit-way word[blk_offset] <= data_in, way dirty <= 1, way MRU; done_cache=1 in N+1; other words unchanged.
REQ-026 Miss (read or write): state unchanged; cycle N+1 miss=1, dirty_block_out/victim_tag/dirty_bit = victim contents; done_cache=0.
REQ-027 Victim = lowest-index invalid way of set; if all valid, LRU way.
REQ-028 Refill: victim way <= data_in_mem, tag, valid=1, dirty=0, MRU; done_cache=1 in N+1; refill does not write data_in.
REQ-029 LRU: per-way age of log2(WAYS) bits per set; touched way -> 0, ways with smaller age +1, others hold; ages within a set always a permutation of 0..WAYS-1.
REQ-030 WAYS=1: behaves as direct-mapped; victim always way 0; no age state.
REQ-031 Multiple-way tag match SHALL not occur by construction; refill of a tag already present is caller error, behaviour unspecified.
REQ-032 data_out, dirty_block_out, victim_tag hold value until next qualifying event.

Reset
REQ-033 rst=1 at edge: all valid, dirty bits 0; ages set to way index; data_out, dirty_block_out, victim_tag, dirty_bit, done_cache, miss = 0.
REQ-034 rst dominates any simultaneous request; request in reset cycle gets no response; data array contents need not be cleared.

Configuration
REQ-035 Macro CACHE_PERF_CNT_EN defined: outputs hit_count, miss_count (32 bits each) count completed hits and misses, saturate at 0xFFFFFFFF, clear on rst.
REQ-036 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-037 Reset, read idx 5 tag 0x1 -> next cycle miss=1, dirty_bit=0, done_cache=0.
REQ-038 Refill idx 5 tag 0x1 block 0x44..33..22..11 (words 3..0), then read offset 2 -> hit=1, data_out=0x33, done_cache=1.
REQ-039 Write hit idx 5 offset 0 data 0xDEADBEEF, refill tag 0x2 same set, then read tag 0x3 -> miss, dirty_bit=1, victim_tag=0x1, dirty_block_out word0=0xDEADBEEF (WAYS=2).
REQ-040 Set full with ways A,B; read A; miss on C -> victim is B; refill C; read A -> hit.
REQ-041 refill and write_en_cache same cycle -> only refill applied, one done_cache pulse, target word unchanged.
REQ-042 rst asserted in cycle after write hit issued -> done_cache=0, later read of that line misses.
